scan_decode_mod: RTL and testbench

SCAN_DECODE_MOD -- requirements
Module: scan_decode_mod

---
 rtl/smg_pkg.sv | 25 ++
 rtl/seg7_decode_mod.sv | 32 +++
 rtl/scan_decode_mod.sv | 176 +++++++++++++++++
 tb/tb_scan_decode_mod.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment codes,
// column select values and the sampling FSM state type.
package smg_pkg;

   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;

   localparam logic [5:0] SEL_ONES = 6'b111110;
   localparam logic [5:0] SEL_TENS = 6'b111101;

   typedef enum logic [1:0] {
      WAIT_STABLE = 2'd0,
      SAMPLE      = 2'd1,
      HOLD        = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_decode_mod.sv
// Combinational inverse of the seven-segment encoder: active-low pattern to BCD
// digit, with the decimal point ignored and an illegal flag for unknown codes.
module seg7_decode_mod
   import smg_pkg::*;
(
   input  logic [7:0] pattern_i,
   output logic [3:0] digit_o,
   output logic       illegal_o
);

   logic [7:0] seg_m;
   assign seg_m = pattern_i | 8'h80;

   always_comb begin
      digit_o   = 4'd0;
      illegal_o = 1'b0;
      case (seg_m)
         SEG_0:   digit_o = 4'd0;
         SEG_1:   digit_o = 4'd1;
         SEG_2:   digit_o = 4'd2;
         SEG_3:   digit_o = 4'd3;
         SEG_4:   digit_o = 4'd4;
         SEG_5:   digit_o = 4'd5;
         SEG_6:   digit_o = 4'd6;
         SEG_7:   digit_o = 4'd7;
         SEG_8:   digit_o = 4'd8;
         SEG_9:   digit_o = 4'd9;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/scan_decode_mod.sv
// Recovers a two-digit value from a multiplexed seven-segment scan, publishing it
// only after MATCH_FRAMES identical complete frames.
//
// state       | meaning
// WAIT_STABLE | waiting for the scan inputs to settle on a legal column
// SAMPLE      | decode the settled digit into the frame register
// HOLD        | digit taken, waiting for the scan to move on
module scan_decode_mod
   import smg_pkg::*;
#(
   parameter int STABLE_CNT   = 16,
   parameter int MATCH_FRAMES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] Row_Scan_Sig,
   input  logic [5:0] Column_Scan_Sig,
   output logic [3:0] ten_data,
   output logic [3:0] one_data,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       seg_error
);

   localparam int SW = $clog2(STABLE_CNT + 1);
   localparam int MW = $clog2(MATCH_FRAMES + 1);
   localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CNT - 1);
   localparam logic [MW-1:0] MATCH_MAX = MW'(MATCH_FRAMES);

   state_t        state_q, state_d;
   logic [13:0]   pair_q;
   logic [SW-1:0] stab_q, stab_d;
   logic          ten_cap_q, ten_cap_d, one_cap_q, one_cap_d;
   logic [3:0]    ten_frm_q, ten_frm_d, one_frm_q, one_frm_d;
   logic [3:0]    prev_ten_q, prev_ten_d, prev_one_q, prev_one_d;
   logic [MW-1:0] match_q, match_d;
   logic          seen_q, seen_d;
   logic [3:0]    ten_out_q, ten_out_d, one_out_q, one_out_d;
   logic [7:0]    dout_q, dout_d;
   logic          valid_q, valid_d, err_q, err_d;

   logic [13:0]   pair_in;
   logic          pair_chg, is_tens, col_legal, dec_illegal, t_cap, o_cap;
   logic [5:0]    col_s;
   logic [3:0]    dec_digit, t_frm, o_frm;
   logic [7:0]    frm_bin;

   assign pair_in   = {Column_Scan_Sig, Row_Scan_Sig};
   assign pair_chg  = (pair_in != pair_q);
   assign col_s     = pair_q[13:8];
   assign is_tens   = (col_s == SEL_TENS);
   assign col_legal = (col_s == SEL_ONES) || (col_s == SEL_TENS);

   seg7_decode_mod u_dec (
      .pattern_i (pair_q[7:0]),
      .digit_o   (dec_digit),
      .illegal_o (dec_illegal)
   );

   // Frame as it would look with the digit under decode merged in.
   assign t_frm   = is_tens ? dec_digit : ten_frm_q;
   assign o_frm   = is_tens ? one_frm_q : dec_digit;
   assign t_cap   = ten_cap_q | is_tens;
   assign o_cap   = one_cap_q | ~is_tens;
   assign frm_bin = ({4'd0, t_frm} << 3) + ({4'd0, t_frm} << 1) + {4'd0, o_frm};

   always_comb begin
      state_d    = state_q;
      stab_d     = stab_q;
      ten_cap_d  = ten_cap_q;
      one_cap_d  = one_cap_q;
      ten_frm_d  = ten_frm_q;
      one_frm_d  = one_frm_q;
      prev_ten_d = prev_ten_q;
      prev_one_d = prev_one_q;
      match_d    = match_q;
      seen_d     = seen_q;
      ten_out_d  = ten_out_q;
      one_out_d  = one_out_q;
      dout_d     = dout_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;

      if (pair_chg)               stab_d = '0;
      else if (stab_q < STAB_MAX) stab_d = stab_q + SW'(1);

      case (state_q)
         WAIT_STABLE: begin
            if (!pair_chg && (stab_q == STAB_MAX) && col_legal) state_d = SAMPLE;
         end
         SAMPLE: begin
            state_d = HOLD;
            if (dec_illegal) begin
               err_d     = 1'b1;
               ten_cap_d = 1'b0;
               one_cap_d = 1'b0;
               match_d   = '0;
            end else begin
               ten_frm_d = t_frm;
               one_frm_d = o_frm;
               if (t_cap && o_cap) begin
                  ten_cap_d  = 1'b0;
                  one_cap_d  = 1'b0;
                  prev_ten_d = t_frm;
                  prev_one_d = o_frm;
                  if ((t_frm == prev_ten_q) && (o_frm == prev_one_q))
                     match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
                  else
                     match_d = MW'(1);
                  if ((match_d == MATCH_MAX) && (match_q != MATCH_MAX) &&
                      (!seen_q || (t_frm != ten_out_q) || (o_frm != one_out_q))) begin
                     ten_out_d = t_frm;
                     one_out_d = o_frm;
                     dout_d    = frm_bin;
                     valid_d   = 1'b1;
                     seen_d    = 1'b1;
                  end
               end else begin
                  ten_cap_d = t_cap;
                  one_cap_d = o_cap;
               end
            end
         end
         HOLD: begin
            // A change seen during SAMPLE shows up only as a cleared counter.
            if (pair_chg || (stab_q == '0)) state_d = WAIT_STABLE;
         end
         default: state_d = WAIT_STABLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= WAIT_STABLE;
         pair_q     <= '0;
         stab_q     <= '0;
         ten_cap_q  <= 1'b0;
         one_cap_q  <= 1'b0;
         ten_frm_q  <= '0;
         one_frm_q  <= '0;
         prev_ten_q <= '0;
         prev_one_q <= '0;
         match_q    <= '0;
         seen_q     <= 1'b0;
         ten_out_q  <= '0;
         one_out_q  <= '0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pair_q     <= pair_in;
         stab_q     <= stab_d;
         ten_cap_q  <= ten_cap_d;
         one_cap_q  <= one_cap_d;
         ten_frm_q  <= ten_frm_d;
         one_frm_q  <= one_frm_d;
         prev_ten_q <= prev_ten_d;
         prev_one_q <= prev_one_d;
         match_q    <= match_d;
         seen_q     <= seen_d;
         ten_out_q  <= ten_out_d;
         one_out_q  <= one_out_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign ten_data   = ten_out_q;
   assign one_data   = one_out_q;
   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign seg_error  = err_q;

endmodule

// File: tb/tb_scan_decode_mod.sv
// Directed bench for scan_decode_mod: a table of multi-frame values plus hand
// sequences for short holds, bad segments, alternation, mid-frame reset and latency.
module tb_scan_decode_mod;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] Row_Scan_Sig;
   logic [5:0] Column_Scan_Sig;
   logic [3:0] ten_data, one_data;
   logic [7:0] data_out;
   logic       data_valid, seg_error;

   localparam logic [5:0] C_ONES  = 6'b111110;
   localparam logic [5:0] C_TENS  = 6'b111101;
   localparam logic [5:0] C_BLANK = 6'b111111;
   localparam int HOLD_CYC = 24;
   // Settle (16 identical cycles) + WAIT->SAMPLE + SAMPLE->output register.
   localparam int LAT_NEG = 19;

   always #5 CLK = ~CLK;

   scan_decode_mod #(.STABLE_CNT(16), .MATCH_FRAMES(2)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .Row_Scan_Sig    (Row_Scan_Sig),
      .Column_Scan_Sig (Column_Scan_Sig),
      .ten_data        (ten_data),
      .one_data        (one_data),
      .data_out        (data_out),
      .data_valid      (data_valid),
      .seg_error       (seg_error)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0, pulses = 0, seg_errs = 0, valid_cyc = 0;
   int last_dout = -1, prev_dout = -1;

   always @(negedge CLK) begin
      cyc++;
      if (data_valid) begin
         pulses++;
         valid_cyc = cyc;
         prev_dout = last_dout;
         last_dout = int'(data_out);
      end
      if (seg_error) seg_errs++;
   end

   typedef struct {
      int ten;
      int one;
      int frames;
      int exp_pulses;
      int exp_ten;
      int exp_one;
      int exp_dout;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [7:0] seg(input int d);
      case (d)
         0: seg = 8'hC0;  1: seg = 8'hF9;  2: seg = 8'hA4;  3: seg = 8'hB0;
         4: seg = 8'h99;  5: seg = 8'h92;  6: seg = 8'h82;  7: seg = 8'hF8;
         8: seg = 8'h80;  9: seg = 8'h90;
         default: seg = 8'hFF;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_digit(input logic [5:0] c, input logic [7:0] p, input int hold);
      Column_Scan_Sig = c;
      Row_Scan_Sig    = p;
      tick(hold);
   endtask

   task automatic send_frame(input int t, input int o, input int hold);
      send_digit(C_TENS, seg(t), hold);
      send_digit(C_ONES, seg(o), hold);
   endtask

   task automatic blank_idle();
      send_digit(C_BLANK, 8'hFF, 30);
   endtask

   task automatic do_reset();
      RST             = 1'b1;
      Column_Scan_Sig = C_BLANK;
      Row_Scan_Sig    = 8'hFF;
      tick(2);
      RST = 1'b0;
      tick(1);
   endtask

   int base_p, base_e, apply_cyc;

   initial begin
      vecs[0] = '{7, 5, 2, 1, 7, 5, 75};
      vecs[1] = '{4, 2, 2, 1, 4, 2, 42};
      vecs[2] = '{9, 9, 3, 1, 9, 9, 99};
      vecs[3] = '{0, 0, 2, 1, 0, 0, 0};
      vecs[4] = '{3, 6, 2, 1, 3, 6, 36};
      vecs[5] = '{8, 6, 1, 0, 0, 0, 0};
      vecs[6] = '{5, 8, 2, 1, 5, 8, 58};
      vecs[7] = '{1, 3, 2, 1, 1, 3, 13};

      RST             = 1'b1;
      Column_Scan_Sig = C_BLANK;
      Row_Scan_Sig    = 8'hFF;
      tick(2);
      check("rst_ten", int'(ten_data), 0);
      check("rst_one", int'(one_data), 0);
      check("rst_dout", int'(data_out), 0);
      check("rst_valid", int'(data_valid), 0);
      check("rst_err", int'(seg_error), 0);
      RST = 1'b0;
      tick(1);

      for (int i = 0; i < 8; i++) begin
         do_reset();
         base_p = pulses;
         base_e = seg_errs;
         for (int f = 0; f < vecs[i].frames; f++) send_frame(vecs[i].ten, vecs[i].one, HOLD_CYC);
         blank_idle();
         check($sformatf("vec%0d_pulses", i), pulses - base_p, vecs[i].exp_pulses);
         check($sformatf("vec%0d_ten", i), int'(ten_data), vecs[i].exp_ten);
         check($sformatf("vec%0d_one", i), int'(one_data), vecs[i].exp_one);
         check($sformatf("vec%0d_dout", i), int'(data_out), vecs[i].exp_dout);
         check($sformatf("vec%0d_segerr", i), seg_errs - base_e, 0);
      end

      // Digits held shorter than the settle time are never sampled.
      do_reset();
      base_p = pulses;
      for (int f = 0; f < 3; f++) send_frame(7, 5, 10);
      blank_idle();
      check("short_pulses", pulses - base_p, 0);
      check("short_dout", int'(data_out), 0);
      check("short_ten", int'(ten_data), 0);

      // Illegal tens pattern, then clean 42 frames.
      do_reset();
      base_p = pulses;
      base_e = seg_errs;
      send_digit(C_TENS, 8'hFF, HOLD_CYC);
      send_digit(C_ONES, seg(2), HOLD_CYC);
      send_frame(4, 2, HOLD_CYC);
      check("bad_early_pulses", pulses - base_p, 0);
      send_frame(4, 2, HOLD_CYC);
      blank_idle();
      check("bad_segerr", seg_errs - base_e, 1);
      check("bad_pulses", pulses - base_p, 1);
      check("bad_dout", int'(data_out), 42);

      // Alternating frames never match; two 13s then publish once.
      do_reset();
      base_p = pulses;
      send_frame(1, 2, HOLD_CYC);
      send_frame(1, 3, HOLD_CYC);
      send_frame(1, 2, HOLD_CYC);
      send_frame(1, 3, HOLD_CYC);
      check("alt_pulses", pulses - base_p, 0);
      send_frame(1, 3, HOLD_CYC);
      send_frame(1, 3, HOLD_CYC);
      blank_idle();
      check("alt13_pulses", pulses - base_p, 1);
      check("alt13_dout", int'(data_out), 13);

      // Reset mid-frame discards the captured tens digit.
      do_reset();
      send_frame(7, 5, HOLD_CYC);
      send_frame(7, 5, HOLD_CYC);
      check("pre_rst_dout", int'(data_out), 75);
      send_digit(C_TENS, seg(9), HOLD_CYC);
      RST             = 1'b1;
      Column_Scan_Sig = C_BLANK;
      Row_Scan_Sig    = 8'hFF;
      tick(1);
      check("midrst_ten", int'(ten_data), 0);
      check("midrst_one", int'(one_data), 0);
      check("midrst_dout", int'(data_out), 0);
      check("midrst_valid", int'(data_valid), 0);
      RST = 1'b0;
      base_p = pulses;
      send_digit(C_ONES, seg(9), HOLD_CYC);
      send_digit(C_TENS, seg(0), HOLD_CYC);
      check("midrst_first_frame", pulses - base_p, 0);
      send_digit(C_ONES, seg(9), HOLD_CYC);
      send_digit(C_TENS, seg(0), HOLD_CYC);
      blank_idle();
      check("midrst_pulses", pulses - base_p, 1);
      check("midrst_dout9", int'(data_out), 9);
      check("midrst_one9", int'(one_data), 9);

      // 99 then 00, three frames each.
      do_reset();
      base_p = pulses;
      for (int f = 0; f < 3; f++) send_frame(9, 9, HOLD_CYC);
      for (int f = 0; f < 3; f++) send_frame(0, 0, HOLD_CYC);
      blank_idle();
      check("9900_pulses", pulses - base_p, 2);
      check("9900_first", prev_dout, 99);
      check("9900_second", last_dout, 0);

      // Tens sampled twice before ones: later capture wins; dp bit ignored.
      do_reset();
      base_p = pulses;
      send_digit(C_TENS, seg(3), HOLD_CYC);
      send_digit(C_TENS, seg(5) & 8'h7F, HOLD_CYC);
      send_digit(C_ONES, seg(1), HOLD_CYC);
      send_frame(5, 1, HOLD_CYC);
      blank_idle();
      check("ovr_pulses", pulses - base_p, 1);
      check("ovr_dout", int'(data_out), 51);

      // Latency from the completing digit to data_valid.
      do_reset();
      base_p = pulses;
      send_frame(6, 4, HOLD_CYC);
      send_digit(C_TENS, seg(6), HOLD_CYC);
      apply_cyc = cyc;
      send_digit(C_ONES, seg(4), HOLD_CYC);
      blank_idle();
      check("lat_pulses", pulses - base_p, 1);
      check("lat_cycles", valid_cyc - apply_cyc, LAT_NEG);
      check("lat_dout", int'(data_out), 64);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
